// File: rtl/bp_mem_channel_arbiter_pkg.sv
// Shared types and the rotating-priority grant helper for the memory channel arbiter.
package bp_mem_channel_arbiter_pkg;

    typedef enum logic {
        e_arb_round_robin = 1'b0,
        e_arb_fixed       = 1'b1
    } arb_mode_e;

    localparam int unsigned max_channels_gp = 32;

    // One-hot grant of the first set bit of v searched from last+1 (mod n);
    // fixed priority is the special case last = n-1.
    function automatic logic [max_channels_gp-1:0] rr_next(
        input int unsigned                last,
        input logic [max_channels_gp-1:0] v,
        input int unsigned                n
    );
        logic [max_channels_gp-1:0]         grant;
        logic [$clog2(max_channels_gp)-1:0] pos;
        grant = '0;
        for (int unsigned k = 0; k < max_channels_gp; k++) begin
            pos = $clog2(max_channels_gp)'((last + 1 + k) % n);
            if (k < n && grant == '0 && v[pos]) begin
                grant[pos] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/bp_mem_channel_arbiter_if.sv
// Channel-side and memory-side handshake bundle of the memory channel arbiter.
interface bp_mem_channel_arbiter_if #(
    parameter int num_channels_p = 2,
    parameter int msg_width_p    = 8
);
    logic [num_channels_p-1:0][msg_width_p-1:0] cmd_i;
    logic [num_channels_p-1:0]                  cmd_v_i;
    logic [num_channels_p-1:0]                  cmd_ready_o;
    logic [msg_width_p-1:0]                     resp_o;
    logic [num_channels_p-1:0]                  resp_v_o;
    logic [num_channels_p-1:0]                  resp_yumi_i;
    logic [msg_width_p-1:0]                     mem_cmd_o;
    logic                                       mem_cmd_v_o;
    logic                                       mem_cmd_ready_i;
    logic [msg_width_p-1:0]                     mem_resp_i;
    logic                                       mem_resp_v_i;
    logic                                       mem_resp_yumi_o;

    modport slave (
        input  cmd_i, cmd_v_i, resp_yumi_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
        output cmd_ready_o, resp_o, resp_v_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
    );

    modport master (
        output cmd_i, cmd_v_i, resp_yumi_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
        input  cmd_ready_o, resp_o, resp_v_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
    );
endinterface

// File: rtl/bp_mem_channel_arbiter_fifo.sv
// Small circular FIFO holding the channel ID of every in-flight memory command.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 1,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r, rptr_r;
    logic [cnt_w_lp-1:0] count_r;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign full_o  = (count_r == cnt_w_lp'(els_p));
    assign empty_o = (count_r == '0);
    assign data_o  = mem_r[rptr_r];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (v_i)    wptr_r <= bump(wptr_r);
            if (yumi_i) rptr_r <= bump(rptr_r);
            if (v_i && !yumi_i)      count_r <= count_r + cnt_w_lp'(1);
            else if (!v_i && yumi_i) count_r <= count_r - cnt_w_lp'(1);
        end
    end
endmodule

// File: rtl/bp_mem_channel_arbiter.sv
// Merges N CCE memory channels onto one memory port and steers in-order
// responses back to the issuing channel via a channel-ID tag FIFO.
module bp_mem_channel_arbiter
    import bp_mem_channel_arbiter_pkg::*;
#(
    parameter int        num_channels_p    = 2,
    parameter int        msg_width_p       = 64,
    parameter int        max_outstanding_p = 8,
    parameter arb_mode_e arb_mode_p        = e_arb_round_robin
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    bp_mem_channel_arbiter_if.slave                io,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   error_o
);
    localparam int tag_w_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    logic                      tag_full, tag_empty;
    logic                      push, pop, resp_ok;
    logic [tag_w_lp-1:0]       head, grant_id, last_grant_r;
    logic [num_channels_p-1:0] eligible, grant, resp_v;
    logic [msg_width_p-1:0]    granted_cmd;
    logic [cnt_w_lp-1:0]       outstanding_r;
    logic                      error_r;

    // Full is taken from registered state only: a same-cycle pop never frees a slot.
    always_comb begin
        eligible = (io.mem_cmd_ready_i && !tag_full && !reset_i) ? io.cmd_v_i : '0;
        if (arb_mode_p == e_arb_fixed) begin
            grant = num_channels_p'(rr_next(32'(num_channels_p - 1),
                                            max_channels_gp'(eligible), 32'(num_channels_p)));
        end else begin
            grant = num_channels_p'(rr_next(32'(last_grant_r),
                                            max_channels_gp'(eligible), 32'(num_channels_p)));
        end
        grant_id    = '0;
        granted_cmd = '0;
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            if (grant[i]) begin
                grant_id    = tag_w_lp'(i);
                granted_cmd = io.cmd_i[i];
            end
        end
        push = |grant;
    end

    always_comb begin
        resp_ok = io.mem_resp_v_i && !tag_empty && !reset_i;
        resp_v  = '0;
        for (int unsigned i = 0; i < num_channels_p; i++) begin
            resp_v[i] = resp_ok && (head == tag_w_lp'(i));
        end
        pop = |(resp_v & io.resp_yumi_i);
    end

    assign io.cmd_ready_o     = grant;
    assign io.mem_cmd_v_o     = push;
    assign io.mem_cmd_o       = granted_cmd;
    assign io.resp_o          = io.mem_resp_i;
    assign io.resp_v_o        = resp_v;
    assign io.mem_resp_yumi_o = pop;
    assign outstanding_o      = outstanding_r;
    assign error_o            = error_r;

    bsg_fifo_1r1w_small #(
        .width_p (tag_w_lp),
        .els_p   (max_outstanding_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (push),
        .data_i  (grant_id),
        .yumi_i  (pop),
        .data_o  (head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // last_grant is only consulted in round-robin mode, so it can track unconditionally.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_r  <= tag_w_lp'(num_channels_p - 1);
            outstanding_r <= '0;
            error_r       <= 1'b0;
        end else begin
            if (push) last_grant_r <= grant_id;
            if (push && !pop)      outstanding_r <= outstanding_r + cnt_w_lp'(1);
            else if (!push && pop) outstanding_r <= outstanding_r - cnt_w_lp'(1);
            if (io.mem_resp_v_i && tag_empty) error_r <= 1'b1;
        end
    end
endmodule
